settings_fetch_scheduler: RTL and testbench

//  Sequences reads of settings words from the controller BRAM over the cnt_bus read port.
//  Up to NUM_REQ settings groups (mod, stm, silencer, sync, pulse-width encoder, debug) each

---
 rtl/settings_fetch_scheduler.sv | 197 +++++++++++++++++++
 tb/tb_settings_fetch_scheduler.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/settings_fetch_scheduler.sv
// settings_fetch_scheduler
//   Reloads settings groups from the controller BRAM over the cnt_bus read
//   port. Each group raises a reload request with a rising edge on its flag
//   bit. Pending groups are served round-robin. The served group gets one
//   pipelined burst of reads, one read per cycle. Every returned word is
//   streamed out with its index. A one-cycle done pulse marks the end of the
//   group's burst.
//
// Ports
//   clk         system clock
//   rst         asynchronous, active-high reset
//   flag        per-group reload request levels (rising edge = request)
//   base_addr   per-group start address, packed, static while busy
//   len         per-group word count, packed, static while busy
//   bus_en      cnt_bus read enable
//   bus_addr    cnt_bus read address (0 when not reading)
//   bus_rdata   cnt_bus read data, valid RD_LATENCY cycles after bus_en
//   word_valid  word_data / word_idx / grant valid this cycle
//   word_idx    index of the returned word within its burst
//   word_data   returned word (0 when word_valid is low)
//   grant       group currently served
//   done        one-hot, one-cycle pulse when a group's burst is delivered
//   busy        high in every state except IDLE
//
// State table
//   state  | meaning
//   IDLE   | waiting; grants the next pending group round-robin
//   ISSUE  | one read per cycle at base + k, k = 0..len-1
//   DRAIN  | RD_LATENCY cycles for the last read's data to return
//   DONE   | pulse done[grant], advance the round-robin pointer

module settings_fetch_scheduler #(
  parameter int NUM_REQ    = 6,
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 16,
  parameter int LEN_WIDTH  = 6,
  parameter int RD_LATENCY = 2
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_REQ-1:0]              flag,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]   base_addr,
  input  logic [NUM_REQ*LEN_WIDTH-1:0]    len,
  output logic                            bus_en,
  output logic [ADDR_WIDTH-1:0]           bus_addr,
  input  logic [DATA_WIDTH-1:0]           bus_rdata,
  output logic                            word_valid,
  output logic [LEN_WIDTH-1:0]            word_idx,
  output logic [DATA_WIDTH-1:0]           word_data,
  output logic [$clog2(NUM_REQ)-1:0]      grant,
  output logic [NUM_REQ-1:0]              done,
  output logic                            busy
);

  localparam int GRANT_WIDTH = $clog2(NUM_REQ);
  localparam int DRAIN_WIDTH = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                  state_q, state_d;
  logic [GRANT_WIDTH-1:0]  grant_q;
  logic [GRANT_WIDTH-1:0]  rr_ptr_q;
  logic [LEN_WIDTH-1:0]    k_q;
  logic [DRAIN_WIDTH-1:0]  drain_q;
  logic [NUM_REQ-1:0]      pending_q;
  logic [NUM_REQ-1:0]      flag_d_q;

  logic [NUM_REQ-1:0]      rise;
  logic                    req_any;
  logic [GRANT_WIDTH-1:0]  sel;
  logic [NUM_REQ-1:0]      sel_oh;
  logic [NUM_REQ-1:0]      grant_oh;
  logic [NUM_REQ-1:0]      grant_clr;
  logic [LEN_WIDTH-1:0]    len_new;
  logic [LEN_WIDTH-1:0]    len_cur;
  logic [ADDR_WIDTH-1:0]   base_cur;
  logic                    last_issue;

  logic [RD_LATENCY-1:0]   rv_q;
  logic [LEN_WIDTH-1:0]    ri_q [RD_LATENCY];

  assign rise     = flag & ~flag_d_q;
  assign req_any  = |pending_q;
  assign sel_oh   = NUM_REQ'(1) << sel;
  assign grant_oh = NUM_REQ'(1) << grant_q;
  assign len_new  = len[int'(sel) * LEN_WIDTH +: LEN_WIDTH];
  assign len_cur  = len[int'(grant_q) * LEN_WIDTH +: LEN_WIDTH];
  assign base_cur = base_addr[int'(grant_q) * ADDR_WIDTH +: ADDR_WIDTH];
  assign last_issue = (k_q == len_cur - LEN_WIDTH'(1));
  assign grant_clr  = (state_q == S_IDLE && req_any) ? sel_oh : '0;

  // Round-robin pick: first pending group at or above rr_ptr, with wrap.
  // The loop runs downward, so the nearest candidate is written last and wins.
  always_comb begin
    int idx;
    sel = '0;
    idx = 0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      idx = (int'(rr_ptr_q) + i) % NUM_REQ;
      if (pending_q[idx]) sel = GRANT_WIDTH'(idx);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (req_any) state_d = (len_new == '0) ? S_DONE : S_ISSUE;
      S_ISSUE: if (last_issue) state_d = S_DRAIN;
      S_DRAIN: if (drain_q == '0) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    bus_en   = 1'b0;
    bus_addr = '0;
    done     = '0;
    busy     = (state_q != S_IDLE);
    case (state_q)
      S_ISSUE: begin
        bus_en   = 1'b1;
        // Address wraps silently at the top of the address space.
        bus_addr = base_cur + ADDR_WIDTH'(k_q);
      end
      S_DONE:  done = grant_oh;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant_q   <= '0;
      rr_ptr_q  <= '0;
      k_q       <= '0;
      drain_q   <= '0;
      pending_q <= '0;
      flag_d_q  <= '0;
    end else begin
      flag_d_q  <= flag;
      // A new edge in the grant cycle overrides the clear.
      pending_q <= (pending_q & ~grant_clr) | rise;
      case (state_q)
        S_IDLE: begin
          if (req_any) begin
            grant_q <= sel;
            k_q     <= '0;
          end
        end
        S_ISSUE: begin
          k_q     <= k_q + LEN_WIDTH'(1);
          drain_q <= DRAIN_WIDTH'(RD_LATENCY - 1);
        end
        S_DRAIN: begin
          if (drain_q != '0) drain_q <= drain_q - DRAIN_WIDTH'(1);
        end
        S_DONE: begin
          rr_ptr_q <= (grant_q == GRANT_WIDTH'(NUM_REQ - 1)) ? '0
                                                             : grant_q + GRANT_WIDTH'(1);
        end
        default: ;
      endcase
    end
  end

  // Return path: {valid, index} travel with each read so they line up
  // with bus_rdata RD_LATENCY cycles later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rv_q <= '0;
      for (int i = 0; i < RD_LATENCY; i++) ri_q[i] <= '0;
    end else begin
      rv_q[0] <= bus_en;
      ri_q[0] <= k_q;
      for (int i = 1; i < RD_LATENCY; i++) begin
        rv_q[i] <= rv_q[i-1];
        ri_q[i] <= ri_q[i-1];
      end
    end
  end

  assign word_valid = rv_q[RD_LATENCY-1];
  assign word_idx   = word_valid ? ri_q[RD_LATENCY-1] : '0;
  assign word_data  = word_valid ? bus_rdata : '0;
  assign grant      = grant_q;

endmodule

// File: tb/tb_settings_fetch_scheduler.sv
// Bench for settings_fetch_scheduler: a table of per-cycle vectors for the
// first burst out of reset, then hand-written sequences for round-robin,
// zero-length, wrap/re-arm, abort and data integrity. A BRAM model with a
// two-cycle read latency supplies bus_rdata.

module tb_settings_fetch_scheduler;

  logic        clk;
  logic        rst;
  logic [5:0]  flag;
  logic [47:0] base_bus;
  logic [35:0] len_bus;
  logic        bus_en;
  logic [7:0]  bus_addr;
  logic [15:0] bus_rdata;
  logic        word_valid;
  logic [5:0]  word_idx;
  logic [15:0] word_data;
  logic [2:0]  grant;
  logic [5:0]  done;
  logic        busy;

  logic [7:0]  base_a [6];
  logic [5:0]  len_a  [6];
  logic [15:0] mem    [256];
  logic [7:0]  a1, a2;

  int checks;
  int errors;

  settings_fetch_scheduler #(
    .NUM_REQ(6), .ADDR_WIDTH(8), .DATA_WIDTH(16), .LEN_WIDTH(6), .RD_LATENCY(2)
  ) dut (
    .clk(clk), .rst(rst), .flag(flag), .base_addr(base_bus), .len(len_bus),
    .bus_en(bus_en), .bus_addr(bus_addr), .bus_rdata(bus_rdata),
    .word_valid(word_valid), .word_idx(word_idx), .word_data(word_data),
    .grant(grant), .done(done), .busy(busy)
  );

  for (genvar gi = 0; gi < 6; gi++) begin : g_pack
    assign base_bus[gi*8 +: 8] = base_a[gi];
    assign len_bus[gi*6 +: 6]  = len_a[gi];
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // BRAM model: address registered twice, data read combinationally.
  always @(posedge clk) begin
    a1 <= bus_addr;
    a2 <= a1;
  end
  assign bus_rdata = mem[a2];

  // Scoreboard monitor: expected group order comes from exp_q.
  bit          mon_on;
  int          cyc;
  int          exp_q[$];
  int          done_t[$];
  logic [7:0]  addr_log[$];
  int          exp_idx;
  logic        prev_done;
  int          mg;
  logic [7:0]  ma;
  logic [5:0]  moh;

  initial begin
    mon_on = 0; cyc = 0; exp_idx = 0; prev_done = 0;
  end

  always @(negedge clk) begin
    cyc++;
    if (mon_on && !rst) begin
      if (prev_done) begin
        checks++;
        if (busy !== 1'b0) begin
          errors++;
          $display("FAIL idle_gap: busy=%0b after done, required 0", busy);
        end
      end
      if (bus_en) addr_log.push_back(bus_addr);
      if (word_valid) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_word: idx=%0d data=%h, required no word", word_idx, word_data);
        end else begin
          mg = exp_q[0];
          ma = base_a[mg] + 8'(exp_idx);
          if (word_idx !== 6'(exp_idx) || word_data !== mem[ma]) begin
            errors++;
            $display("FAIL word_g%0d: idx=%0d data=%h, required idx=%0d data=%h",
                     mg, word_idx, word_data, exp_idx, mem[ma]);
          end
        end
        exp_idx++;
      end
      if (done != 6'b0) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_done: done=%b, required 000000", done);
        end else begin
          mg  = exp_q.pop_front();
          moh = 6'b000001 << mg;
          if (done !== moh || grant !== 3'(mg) || exp_idx != int'(len_a[mg])) begin
            errors++;
            $display("FAIL done_g%0d: done=%b grant=%0d words=%0d, required done=%b grant=%0d words=%0d",
                     mg, done, grant, exp_idx, moh, mg, len_a[mg]);
          end
        end
        exp_idx = 0;
        done_t.push_back(cyc);
      end
      prev_done = (done != 6'b0);
    end else begin
      prev_done = 1'b0;
    end
  end

  typedef struct {
    logic       rst;
    logic [5:0] flag;
    logic       en;
    logic [7:0] addr;
    logic       wv;
    logic [5:0] idx;
    logic [5:0] done;
    logic       busy;
  } vec_t;

  vec_t tv[11];

  task automatic do_reset();
    @(negedge clk); rst = 1'b1; flag = 6'b0;
    @(negedge clk);
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_q_empty(input int budget, input string nm);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk); #2;
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s: %0d bursts outstanding after %0d cycles, required 0", nm, exp_q.size(), budget);
      exp_q.delete();
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h", nm, act, req);
    end
  endtask

  initial begin
    logic [7:0]  ea;
    logic [15:0] ed;
    logic [39:0] got, want;
    logic        act;
    logic [5:0]  dseen;
    int          span;

    checks = 0; errors = 0;
    rst = 1'b1; flag = 6'b0;
    for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
    base_a[0] = 8'h10; base_a[1] = 8'hFE; base_a[2] = 8'h40;
    base_a[3] = 8'h60; base_a[4] = 8'h80; base_a[5] = 8'hA0;
    for (int i = 0; i < 6; i++) len_a[i] = 6'd0;
    len_a[0] = 6'd3;

    // T1: first burst out of reset, cycle by cycle.
    //           rst   flag   en    addr   wv    idx   done   busy
    tv[0]  = '{1'b1, 6'h01, 1'b0, 8'h00, 1'b0, 6'd0, 6'h00, 1'b0};
    tv[1]  = '{1'b0, 6'h01, 1'b0, 8'h00, 1'b0, 6'd0, 6'h00, 1'b0};
    tv[2]  = '{1'b0, 6'h01, 1'b0, 8'h00, 1'b0, 6'd0, 6'h00, 1'b0};
    tv[3]  = '{1'b0, 6'h01, 1'b1, 8'h10, 1'b0, 6'd0, 6'h00, 1'b1};
    tv[4]  = '{1'b0, 6'h01, 1'b1, 8'h11, 1'b0, 6'd0, 6'h00, 1'b1};
    tv[5]  = '{1'b0, 6'h01, 1'b1, 8'h12, 1'b1, 6'd0, 6'h00, 1'b1};
    tv[6]  = '{1'b0, 6'h01, 1'b0, 8'h00, 1'b1, 6'd1, 6'h00, 1'b1};
    tv[7]  = '{1'b0, 6'h01, 1'b0, 8'h00, 1'b1, 6'd2, 6'h00, 1'b1};
    tv[8]  = '{1'b0, 6'h01, 1'b0, 8'h00, 1'b0, 6'd0, 6'h01, 1'b1};
    tv[9]  = '{1'b0, 6'h01, 1'b0, 8'h00, 1'b0, 6'd0, 6'h00, 1'b0};
    tv[10] = '{1'b0, 6'h01, 1'b0, 8'h00, 1'b0, 6'd0, 6'h00, 1'b0};

    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      rst  = tv[i].rst;
      flag = tv[i].flag;
      #1;
      ea = 8'h10 + {2'b00, tv[i].idx};
      ed = tv[i].wv ? mem[ea] : 16'h0000;
      got  = {bus_en, bus_addr, word_valid, word_idx, done, busy, word_data};
      want = {tv[i].en, tv[i].addr, tv[i].wv, tv[i].idx, tv[i].done, tv[i].busy, ed};
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL t1_vec%0d: en=%b addr=%h wv=%b idx=%0d done=%b busy=%b data=%h, required en=%b addr=%h wv=%b idx=%0d done=%b busy=%b data=%h",
                 i, bus_en, bus_addr, word_valid, word_idx, done, busy, word_data,
                 tv[i].en, tv[i].addr, tv[i].wv, tv[i].idx, tv[i].done, tv[i].busy, ed);
      end
    end
    flag = 6'b0;

    // T2: round-robin 0,2,5; group 0 re-requested during its own burst.
    do_reset();
    len_a[0] = 6'd2; len_a[2] = 6'd2; len_a[5] = 6'd2;
    exp_q = {0, 2, 5, 0};
    exp_idx = 0;
    mon_on = 1;
    @(negedge clk); flag = 6'b100101;
    @(negedge clk); flag = 6'b000000;
    @(negedge clk); flag = 6'b000001;
    @(negedge clk); flag = 6'b000000;
    wait_q_empty(200, "t2_rr");
    mon_on = 0;

    // T3: zero-length group issues no reads, done follows the grant.
    len_a[3] = 6'd0;
    act = 1'b0;
    @(negedge clk); flag = 6'b001000;
    #1 act = act | bus_en | word_valid;
    @(negedge clk); flag = 6'b000000;
    #1 act = act | bus_en | word_valid;
    chk("t3_pending", {62'd0, busy, |done}, 64'd0);
    @(negedge clk);
    #1 act = act | bus_en | word_valid;
    chk("t3_done", {55'd0, done, grant}, {55'd0, 6'b001000, 3'd3});
    @(negedge clk);
    #1 act = act | bus_en | word_valid;
    chk("t3_after", {57'd0, done, busy}, 64'd0);
    repeat (3) begin
      @(negedge clk);
      #1 act = act | bus_en | word_valid;
    end
    chk("t3_no_reads", {63'd0, act}, 64'd0);

    // T4: address wrap and re-arm during ISSUE.
    len_a[1] = 6'd4;
    addr_log.delete();
    done_t.delete();
    exp_q = {1, 1};
    exp_idx = 0;
    mon_on = 1;
    @(negedge clk); flag = 6'b000010;
    @(negedge clk);
    @(negedge clk); flag = 6'b000000;
    @(negedge clk); flag = 6'b000010;
    @(negedge clk); flag = 6'b000000;
    wait_q_empty(200, "t4_rearm");
    mon_on = 0;
    checks++;
    if (addr_log.size() != 8) begin
      errors++;
      $display("FAIL t4_nreads: got %0d reads, required 8", addr_log.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        ea = 8'hFE + 8'(i % 4);
        chk("t4_addr", {56'd0, addr_log[i]}, {56'd0, ea});
      end
    end
    checks++;
    span = (done_t.size() == 2) ? done_t[1] - done_t[0] : -1;
    if (span != 8) begin
      errors++;
      $display("FAIL t4_spacing: done spacing %0d cycles, required 8", span);
    end

    // T5: reset during DRAIN aborts the burst and drops pending requests.
    len_a[4] = 6'd5;
    dseen = 6'b0;
    @(negedge clk); flag = 6'b010000;
    @(negedge clk); flag = 6'b000000;
    @(negedge clk); #1 dseen |= done;
    @(negedge clk); flag = 6'b000100; #1 dseen |= done;
    @(negedge clk); flag = 6'b000000; #1 dseen |= done;
    @(negedge clk); #1 dseen |= done;
    @(negedge clk); #1 dseen |= done;
    @(negedge clk); #1 dseen |= done;
    chk("t5_in_drain", {54'd0, busy, bus_en, word_valid, word_idx, 1'b0},
                       {54'd0, 1'b1, 1'b0, 1'b1, 6'd3, 1'b0});
    rst = 1'b1;
    #1;
    chk("t5_abort", {{14{1'b0}}, bus_en, bus_addr, word_valid, word_idx, word_data, grant, done, busy}, 64'd0);
    @(negedge clk);
    @(negedge clk); rst = 1'b0; flag = 6'b000000;
    act = 1'b0;
    repeat (10) begin
      @(negedge clk);
      #1 act = act | busy | bus_en | word_valid;
      dseen |= done;
    end
    chk("t5_stay_idle", {63'd0, act}, 64'd0);
    chk("t5_no_done", {58'd0, dseen}, 64'd0);

    // T6: all six groups at once, every word scored against the BRAM image.
    do_reset();
    len_a[0] = 6'd3; len_a[1] = 6'd4; len_a[2] = 6'd2;
    len_a[3] = 6'd5; len_a[4] = 6'd1; len_a[5] = 6'd6;
    exp_q = {0, 1, 2, 3, 4, 5};
    exp_idx = 0;
    mon_on = 1;
    @(negedge clk); flag = 6'b111111;
    @(negedge clk); flag = 6'b000000;
    wait_q_empty(300, "t6_all");
    mon_on = 0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
